// File: rtl/ch2_pkg.sv
// Shared types and helpers for the chapter-2 serial link
// (PISO transmitter and its matching SIPO receiver).
package ch2_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int MAX_WIDTH = 32;

  // Reverses the low 'width' bits of v; bits at and above 'width' come back as zero.
  function automatic logic [MAX_WIDTH-1:0] reverse_bits(
    input logic [MAX_WIDTH-1:0] v,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] r;
    r = {MAX_WIDTH{1'b0}};
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        r[width-1-i] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ch2_piso_tx_if.sv
// Word handshake and serial output bundle of the chapter-2 transmitter.
interface ch2_piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             data_out;
  logic             out_valid;
  logic             last;

  modport master (
    output load, data_in,
    input  ready, data_out, out_valid, last
  );

  modport slave (
    input  load, data_in,
    output ready, data_out, out_valid, last
  );
endinterface

// File: rtl/ch2_piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on load/ready
// and shifts it out one bit per clock, streaming back-to-back words gap-free.
module ch2_piso_tx
  import ch2_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic          clk,
  input logic          rst,
  ch2_piso_tx_if.slave bus
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  piso_state_t      state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sh_r;
  logic             out_valid_r;
  logic             last_r;

  logic             at_last_s;
  logic             ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] load_word_s;

  // The register always shifts toward its MSB, so LSB-first words are reversed on load.
  always_comb begin
    if (MSB_FIRST) begin
      load_word_s = bus.data_in;
    end else begin
      load_word_s = WIDTH'(reverse_bits(MAX_WIDTH'(bus.data_in), WIDTH));
    end
  end

  // Handshake: ready in IDLE or on the final bit, so streaming words reload with no gap.
  always_comb begin
    at_last_s = (state_r == SHIFT) && (cnt_r == CNT_LAST);
    ready_s   = !rst && ((state_r == IDLE) || at_last_s);
    accept_s  = bus.load && ready_s;
  end

  // FSM, bit counter, shift register and registered serial flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      sh_r        <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      last_r      <= 1'b0;
    end else if (accept_s) begin
      state_r     <= SHIFT;
      cnt_r       <= {CW{1'b0}};
      sh_r        <= load_word_s;
      out_valid_r <= 1'b1;
      last_r      <= 1'b0;
    end else begin
      case (state_r)
        SHIFT: begin
          if (at_last_s) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            sh_r        <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
          end else begin
            state_r     <= SHIFT;
            cnt_r       <= cnt_r + CW'(1);
            sh_r        <= {sh_r[WIDTH-2:0], 1'b0};
            out_valid_r <= 1'b1;
            last_r      <= ((cnt_r + CW'(1)) == CNT_LAST);
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CW{1'b0}};
          sh_r        <= {WIDTH{1'b0}};
          out_valid_r <= 1'b0;
          last_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_s;
  assign bus.data_out  = sh_r[WIDTH-1];
  assign bus.out_valid = out_valid_r;
  assign bus.last      = last_r;

endmodule

// File: tb/tb_ch2_piso_tx.sv
// Bench for ch2_piso_tx: three transmitters (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first), each looped into a SIPO, checked against a bit-queue model.
module tb_ch2_piso_tx;

  typedef struct packed {
    logic       b;
    logic       l;
    logic [7:0] w;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] ld;
  logic [7:0] din [3];
  ent_t       q [3][$];
  logic [15:0] rec [3];
  logic       pend [3];
  logic [7:0] pend_w [3];
  logic [3:0] sipo0;
  logic [3:0] sipo1;
  logic [7:0] sipo2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ch2_piso_tx_if #(.WIDTH(4)) i0 ();
  ch2_piso_tx_if #(.WIDTH(4)) i1 ();
  ch2_piso_tx_if #(.WIDTH(8)) i2 ();

  assign i0.load    = ld[0];
  assign i0.data_in = din[0][3:0];
  assign i1.load    = ld[1];
  assign i1.data_in = din[1][3:0];
  assign i2.load    = ld[2];
  assign i2.data_in = din[2];

  ch2_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  ch2_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  ch2_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));

  logic [2:0] rdy_s, ov_s, do_s, la_s;
  assign rdy_s = {i2.ready, i1.ready, i0.ready};
  assign ov_s  = {i2.out_valid, i1.out_valid, i0.out_valid};
  assign do_s  = {i2.data_out, i1.data_out, i0.data_out};
  assign la_s  = {i2.last, i1.last, i0.last};

  // Receiving SIPOs with the bit order matching each transmitter.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sipo0 <= 4'd0;
      sipo1 <= 4'd0;
      sipo2 <= 8'd0;
    end else begin
      if (i0.out_valid) sipo0 <= {sipo0[2:0], i0.data_out};
      if (i1.out_valid) sipo1 <= {i1.data_out, sipo1[3:1]};
      if (i2.out_valid) sipo2 <= {sipo2[6:0], i2.data_out};
    end
  end

  function automatic logic [7:0] sipo_of(int d);
    case (d)
      0:       return {4'd0, sipo0};
      1:       return {4'd0, sipo1};
      default: return sipo2;
    endcase
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    chk(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  // A word becomes WIDTH displayed bits in transmit order; the final one is marked last.
  function automatic void push_word(int d, logic [7:0] w);
    int wd;
    ent_t e;
    wd = (d == 2) ? 8 : 4;
    for (int k = 0; k < wd; k++) begin
      e.b = (d == 1) ? w[k] : w[wd-1-k];
      e.l = (k == wd - 1);
      e.w = (wd == 8) ? w : (w & 8'h0F);
      q[d].push_back(e);
    end
  endfunction

  // One clock: model ready decides accepts, edge retires the displayed bit, then outputs are checked.
  task automatic step(output logic [2:0] acc);
    ent_t e;
    logic er;
    for (int d = 0; d < 3; d++) begin
      er = (q[d].size() <= 1);
      chk1($sformatf("ready%0d", d), rdy_s[d], er);
      acc[d] = ld[d] && er;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      pend[d] = 1'b0;
      if (q[d].size() > 0) begin
        e = q[d].pop_front();
        if (e.l) begin
          pend[d]   = 1'b1;
          pend_w[d] = e.w;
        end
      end
      if (acc[d]) push_word(d, din[d]);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (q[d].size() > 0) e = q[d][0];
      else e = '0;
      chk1($sformatf("out_valid%0d", d), ov_s[d], q[d].size() > 0);
      chk1($sformatf("data_out%0d", d), do_s[d], e.b);
      chk1($sformatf("last%0d", d), la_s[d], e.l);
      if (ov_s[d]) rec[d] = {rec[d][14:0], do_s[d]};
      if (pend[d]) chk($sformatf("sipo%0d", d), {8'd0, sipo_of(d)}, {8'd0, pend_w[d]});
    end
  endtask

  task automatic tick();
    logic [2:0] a;
    step(a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld  = 3'b111;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk1($sformatf("rst_now_ov%0d", d), ov_s[d], 1'b0);
      chk1($sformatf("rst_now_do%0d", d), do_s[d], 1'b0);
      chk1($sformatf("rst_now_last%0d", d), la_s[d], 1'b0);
      chk1($sformatf("rst_now_ready%0d", d), rdy_s[d], 1'b0);
      q[d].delete();
      pend[d] = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk1($sformatf("rst_hold_ov%0d", d), ov_s[d], 1'b0);
      chk1($sformatf("rst_hold_ready%0d", d), rdy_s[d], 1'b0);
    end
    rst = 1'b0;
    ld  = 3'b000;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk1($sformatf("post_rst_ready%0d", d), rdy_s[d], 1'b1);
      chk1($sformatf("post_rst_ov%0d", d), ov_s[d], 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] a;
    int t;
    ld = 3'b000;
    for (int d = 0; d < 3; d++) begin
      din[d]  = 8'd0;
      rec[d]  = 16'd0;
      pend[d] = 1'b0;
    end
    do_reset();

    // Single MSB-first word 1011.
    rec[0] = 16'd0; din[0] = 8'h0B; ld[0] = 1'b1; tick(); ld[0] = 1'b0;
    repeat (5) tick();
    chk("msb_stream", rec[0], 16'h000B);

    // Single LSB-first word 1011 -> 1,1,0,1.
    rec[1] = 16'd0; din[1] = 8'h0B; ld[1] = 1'b1; tick(); ld[1] = 1'b0;
    repeat (5) tick();
    chk("lsb_stream", rec[1], 16'h000D);

    // Load held: A then 5, second accept on the LAST cycle.
    rec[0] = 16'd0; din[0] = 8'h0A; ld[0] = 1'b1; tick();
    din[0] = 8'h05;
    repeat (4) tick();
    ld[0] = 1'b0;
    repeat (5) tick();
    chk("stream_a5", rec[0], 16'h00A5);

    // Reset during the second bit of F, then a clean 3.
    din[0] = 8'h0F; ld[0] = 1'b1; tick(); ld[0] = 1'b0; tick();
    do_reset();
    rec[0] = 16'd0; din[0] = 8'h03; ld[0] = 1'b1; tick(); ld[0] = 1'b0;
    repeat (5) tick();
    chk("after_rst_3", rec[0], 16'h0003);

    // data_in toggles and a load pulse while busy leave the word alone.
    rec[0] = 16'd0; din[0] = 8'h06; ld[0] = 1'b1; tick();
    ld[0] = 1'b0; din[0] = 8'h09; tick();
    ld[0] = 1'b1; din[0] = 8'h0C; tick();
    ld[0] = 1'b0; din[0] = 8'h0F;
    repeat (5) tick();
    chk("busy_ignored", rec[0], 16'h0006);

    // 50 random 8-bit words, mixing streaming and idle gaps.
    for (int i = 0; i < 50; i++) begin
      din[2] = 8'($urandom);
      ld[2]  = 1'b1;
      a = 3'b000;
      t = 0;
      while (!a[2] && t < 20) begin
        step(a);
        t++;
      end
      chk1("accept_bound", a[2], 1'b1);
      if ($urandom_range(0, 1) == 0) begin
        ld[2] = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    ld[2] = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
